calculator_top: RTL and testbench

//  Top level of the SRAM-backed 64-bit accumulate calculator.

---
 rtl/calculator_pkg.sv | 15 +
 rtl/calculator_ctrl.sv | 123 ++++++++++++
 rtl/calculator_sram.sv | 47 ++++
 rtl/calculator.sv | 54 +++++
 tb/tb_calculator_top.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/calculator_pkg.sv
// Shared widths and controller state encoding for the SRAM-backed 64-bit calculator.
package calculator_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ1,
        S_READ2,
        S_ADD,
        S_WRITE,
        S_END
    } state_t;
endpackage

// File: rtl/calculator_ctrl.sv
// Controller: walks the read window two words at a time, adds each pair, writes sums.
// CALC_CYCLE_COUNT_EN adds a 32-bit busy-cycle counter (cycle_count).
//   state   | meaning
//   S_IDLE  | latch address window, decide whether there is any work
//   S_READ1 | present first operand address
//   S_READ2 | capture op_a, present second operand address
//   S_ADD   | capture op_b (0 when the window ends on op_a)
//   S_WRITE | write op_a+op_b at w_addr, advance counters
//   S_END   | parked until reset
module calculator_ctrl
    import calculator_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   read_start_addr_i,
    input  logic [ADDR_W-1:0]   read_end_addr_i,
    input  logic [ADDR_W-1:0]   write_start_addr_i,
    input  logic [ADDR_W-1:0]   write_end_addr_i,
    input  logic [2*DATA_W-1:0] sram_rdata_i,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic                sram_we_o,
    output logic [2*DATA_W-1:0] sram_wdata_o,
    output logic [ADDR_W-1:0]   w_addr_o
);
    state_t state, state_d;

    logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
    logic [ADDR_W-1:0]   read_end_q, write_end_q;
    logic [2*DATA_W-1:0] op_a_q, op_b_q;
    logic [ADDR_W:0]     r_next_wide;
    logic                last_operand;
    logic                stop;

    // Widened so a window ending at the top address terminates instead of wrapping.
    assign r_next_wide  = {1'b0, r_addr_q} + (ADDR_W+1)'(2);
    assign last_operand = (r_addr_q == read_end_q);
    assign stop         = (r_next_wide > {1'b0, read_end_q}) || (w_addr_q == write_end_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if ((read_start_addr_i > read_end_addr_i) ||
                    (write_start_addr_i > write_end_addr_i)) begin
                    state_d = S_END;
                end else begin
                    state_d = S_READ1;
                end
            end
            S_READ1: state_d = S_READ2;
            S_READ2: state_d = S_ADD;
            S_ADD:   state_d = S_WRITE;
            S_WRITE: state_d = stop ? S_END : S_READ1;
            S_END:   state_d = S_END;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sram_we_o   = 1'b0;
        sram_addr_o = r_addr_q;
        case (state)
            S_READ2: sram_addr_o = r_addr_q + ADDR_W'(1);
            S_WRITE: begin
                sram_we_o   = 1'b1;
                sram_addr_o = w_addr_q;
            end
            default: ;
        endcase
    end

    assign sram_wdata_o = op_a_q + op_b_q;
    assign w_addr_o     = w_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr_q    <= '0;
            w_addr_q    <= '0;
            read_end_q  <= '0;
            write_end_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    r_addr_q    <= read_start_addr_i;
                    w_addr_q    <= write_start_addr_i;
                    read_end_q  <= read_end_addr_i;
                    write_end_q <= write_end_addr_i;
                end
                S_READ2: op_a_q <= sram_rdata_i;
                S_ADD:   op_b_q <= last_operand ? '0 : sram_rdata_i;
                S_WRITE: begin
                    if (!stop) begin
                        r_addr_q <= r_next_wide[ADDR_W-1:0];
                        w_addr_q <= w_addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CALC_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_count <= '0;
        end else if ((state != S_IDLE) && (state != S_END)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif
endmodule

// File: rtl/calculator_sram.sv
// Single-port 1024x32 SRAM model: synchronous write, 1-cycle registered read.
// The storage array lives in memory_mode_inst.memory so it can be preloaded hierarchically.
module calculator_sram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] memory [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // No reset: contents survive rst and may be written from outside the design.
    always @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
        rdata_q <= memory[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module calculator_sram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    calculator_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) memory_mode_inst (
        .clk_i   (clk_i),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );
endmodule

// File: rtl/calculator.sv
// calculator_top: controller plus low/high word SRAMs; glue only.
// Optional busy-cycle counter inside u_ctrl is enabled by CALC_CYCLE_COUNT_EN.
module calculator_top
    import calculator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_start_addr,
    input  logic [ADDR_W-1:0] read_end_addr,
    input  logic [ADDR_W-1:0] write_start_addr,
    input  logic [ADDR_W-1:0] write_end_addr
);
    logic [ADDR_W-1:0]   sram_addr;
    logic                sram_we;
    logic [2*DATA_W-1:0] sram_wdata;
    logic [2*DATA_W-1:0] sram_rdata;
    logic [ADDR_W-1:0]   w_addr;

    calculator_ctrl u_ctrl (
        .clk_i              (clk),
        .rst_ni             (rst),
        .read_start_addr_i  (read_start_addr),
        .read_end_addr_i    (read_end_addr),
        .write_start_addr_i (write_start_addr),
        .write_end_addr_i   (write_end_addr),
        .sram_rdata_i       (sram_rdata),
        .sram_addr_o        (sram_addr),
        .sram_we_o          (sram_we),
        .sram_wdata_o       (sram_wdata),
        .w_addr_o           (w_addr)
    );

    calculator_sram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) sram_A (
        .clk_i   (clk),
        .addr_i  (sram_addr),
        .we_i    (sram_we),
        .wdata_i (sram_wdata[DATA_W-1:0]),
        .rdata_o (sram_rdata[DATA_W-1:0])
    );

    calculator_sram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) sram_B (
        .clk_i   (clk),
        .addr_i  (sram_addr),
        .we_i    (sram_we),
        .wdata_i (sram_wdata[2*DATA_W-1:DATA_W]),
        .rdata_o (sram_rdata[2*DATA_W-1:DATA_W])
    );
endmodule

// File: tb/tb_calculator_top.sv
// Directed bench for calculator_top: per-write scoreboard plus final memory-image and literal checks.
module tb_calculator_top;
    import calculator_pkg::*;

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    typedef struct {
        int          addr;
        logic [63:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] read_start_addr = '0;
    logic [9:0] read_end_addr = '0;
    logic [9:0] write_start_addr = '0;
    logic [9:0] write_end_addr = '0;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    wr_t exp_q[$];

    logic [31:0] ma [0:1023];
    logic [31:0] mb [0:1023];
    logic [31:0] ea [0:1023];
    logic [31:0] eb [0:1023];

    always #5 clk = ~clk;

    calculator_top dut (
        .clk              (clk),
        .rst              (rst),
        .read_start_addr  (read_start_addr),
        .read_end_addr    (read_end_addr),
        .write_start_addr (write_start_addr),
        .write_end_addr   (write_end_addr)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mem64(input int a);
        return {dut.sram_B.memory_mode_inst.memory[a], dut.sram_A.memory_mode_inst.memory[a]};
    endfunction

    // Every SRAM write is compared against the next expected (address, sum) pair.
    always @(negedge clk) begin
        if (rst && dut.sram_we) begin
            wr_t e;
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         dut.sram_addr, dut.sram_wdata);
            end else begin
                e = exp_q.pop_front();
                if (dut.sram_addr !== e.addr[9:0] || dut.sram_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write_stream: got addr %0d data %0h expected addr %0d data %0h",
                             dut.sram_addr, dut.sram_wdata, e.addr, e.data);
                end
            end
        end
    end

    // Result k = pair (rs+2k, rs+2k+1); an unpaired last operand adds 0; stop on either window end.
    task automatic build_model(input int rs, input int re, input int ws, input int we_);
        int r;
        int w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] s;
        exp_q.delete();
        ea = ma;
        eb = mb;
        if (rs <= re && ws <= we_) begin
            r = rs;
            w = ws;
            for (int k = 0; k < 1024; k++) begin
                a = {mb[r], ma[r]};
                b = (r == re) ? 64'd0 : {mb[r+1], ma[r+1]};
                s = a + b;
                exp_q.push_back('{addr: w, data: s});
                ea[w] = s[31:0];
                eb[w] = s[63:32];
                if (r + 2 > re || w == we_) break;
                r += 2;
                w += 1;
            end
        end
    endtask

    task automatic push_mem();
        for (int i = 0; i < 1024; i++) begin
            dut.sram_A.memory_mode_inst.memory[i] = ma[i];
            dut.sram_B.memory_mode_inst.memory[i] = mb[i];
        end
    endtask

    task automatic fill_base();
        for (int i = 0; i < 1024; i++) begin
            ma[i] = (i < 768) ? 32'(i) : SENT;
            mb[i] = (i < 768) ? 32'd0 : SENT;
        end
    endtask

    task automatic reset_dut(input string nm);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check({nm, "_rst_state"}, 64'(dut.u_ctrl.state), 64'(S_IDLE));
        check({nm, "_rst_w_addr"}, 64'(dut.w_addr), 64'd0);
        check({nm, "_rst_we"}, 64'(dut.sram_we), 64'd0);
`ifdef CALC_CYCLE_COUNT_EN
        check({nm, "_rst_cycle_count"}, 64'(dut.u_ctrl.cycle_count), 64'd0);
`endif
    endtask

    task automatic start(input int rs, input int re, input int ws, input int we_);
        read_start_addr  = rs[9:0];
        read_end_addr    = re[9:0];
        write_start_addr = ws[9:0];
        write_end_addr   = we_[9:0];
        build_model(rs, re, ws, we_);
        n_writes = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_end(input string nm, input int exp_cycles);
        int  cyc;
        int  bad;
        bit  done;
        int  nexp;
        cyc  = 0;
        done = 1'b0;
        nexp = exp_q.size() + n_writes;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.u_ctrl.state == S_END) done = 1'b1;
        end
        check({nm, "_end_reached"}, 64'(done), 64'd1);
        check({nm, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        // Ports changing after start must not matter; S_END must be sticky.
        read_end_addr  = 10'd1023;
        write_end_addr = 10'd1023;
        repeat (6) @(posedge clk);
        #1;
        check({nm, "_end_sticky"}, 64'(dut.u_ctrl.state), 64'(S_END));
        check({nm, "_we_low_at_end"}, 64'(dut.sram_we), 64'd0);
        check({nm, "_write_count"}, 64'(n_writes), 64'(nexp));
`ifdef CALC_CYCLE_COUNT_EN
        check({nm, "_cycle_count"}, 64'(dut.u_ctrl.cycle_count), 64'(exp_cycles - 1));
`endif
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (mem64(i) !== {eb[i], ea[i]}) bad++;
        end
        check({nm, "_memory_image_mismatches"}, 64'(bad), 64'd0);
        ma = ea;
        mb = eb;
    endtask

    initial begin
        bit hit;

        // Test 1: A[i]=i, default windows.
        reset_dut("t1");
        fill_base();
        push_mem();
        start(0, 511, 768, 1023);
        wait_end("t1", 1025);
        check("t1_lit_768", mem64(768), 64'd1);
        check("t1_lit_769", mem64(769), 64'd5);
        check("t1_lit_1023", mem64(1023), 64'd1021);

        // Test 2: carry from low into high word.
        reset_dut("t2");
        fill_base();
        ma[0] = 32'hFFFF_FFFF;
        ma[1] = 32'hFFFF_FFFF;
        push_mem();
        start(0, 511, 768, 1023);
        wait_end("t2", 1025);
        check("t2_lit_carry", mem64(768), 64'h1_FFFF_FFFE);
        check("t2_lit_769", mem64(769), 64'd5);

        // Test 3: 64-bit overflow wraps.
        reset_dut("t3");
        fill_base();
        for (int i = 0; i < 512; i++) begin
            ma[i] = 32'hFFFF_FFFF;
            mb[i] = 32'hFFFF_FFFF;
        end
        push_mem();
        start(0, 511, 768, 1023);
        wait_end("t3", 1025);
        check("t3_lit_768", mem64(768), 64'hFFFF_FFFF_FFFF_FFFE);
        check("t3_lit_1023", mem64(1023), 64'hFFFF_FFFF_FFFF_FFFE);

        // Test 4: odd read window, last operand pairs with 0.
        reset_dut("t4");
        fill_base();
        push_mem();
        start(0, 4, 768, 1023);
        wait_end("t4", 13);
        check("t4_lit_770", mem64(770), 64'd4);
        check("t4_lit_771_untouched", mem64(771), 64'hDEAD_BEEF_DEAD_BEEF);

        // Test 5: write window fills first.
        reset_dut("t5");
        fill_base();
        push_mem();
        start(0, 511, 768, 769);
        wait_end("t5", 9);
        check("t5_lit_769", mem64(769), 64'd5);
        check("t5_lit_770_untouched", mem64(770), 64'hDEAD_BEEF_DEAD_BEEF);

        // Test 6: empty read window goes straight to S_END.
        reset_dut("t6");
        fill_base();
        push_mem();
        start(5, 4, 768, 1023);
        wait_end("t6", 1);
        check("t6_lit_768_untouched", mem64(768), 64'hDEAD_BEEF_DEAD_BEEF);

        // Test 7: reset during S_ADD of pair 10, then full rerun.
        reset_dut("t7");
        fill_base();
        push_mem();
        start(0, 511, 768, 1023);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (dut.u_ctrl.state == S_ADD && n_writes == 10) hit = 1'b1;
        end
        check("t7_reached_pair10_add", 64'(hit), 64'd1);
        rst = 1'b0;
        #1;
        check("t7_abort_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
        check("t7_abort_we", 64'(dut.sram_we), 64'd0);
`ifdef CALC_CYCLE_COUNT_EN
        check("t7_abort_cycle_count", 64'(dut.u_ctrl.cycle_count), 64'd0);
`endif
        check("t7_kept_777", mem64(777), 64'd37);
        check("t7_discarded_778", mem64(778), 64'hDEAD_BEEF_DEAD_BEEF);
        start(0, 511, 768, 1023);
        wait_end("t7_rerun", 1025);
        check("t7_lit_778", mem64(778), 64'd41);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
